// File: rtl/pos2bin_stream.sv
// Multi-hot to binary encoder: one vector in, one index per beat out.
// Indices are emitted LSB-first or MSB-first; all outputs are registered.
module pos2bin_stream #(
  parameter int BIN_WIDTH = 8,
  parameter int POS_WIDTH = 2**BIN_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 pos_valid,
  output logic                 pos_ready,
  input  logic [POS_WIDTH-1:0] pos,
  output logic                 bin_valid,
  input  logic                 bin_ready,
  output logic [BIN_WIDTH-1:0] bin,
  output logic                 bin_last,
  output logic [BIN_WIDTH:0]   hot_cnt,
  output logic                 err_no_hot,
  input  logic                 abort
);

  localparam int CW = BIN_WIDTH + 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [POS_WIDTH-1:0] work;
  logic [POS_WIDTH-1:0] work_nxt;
  logic [BIN_WIDTH:0]   hot_nxt;
  logic                 err_nxt;
  logic [BIN_WIDTH-1:0] bin_nxt;
  logic                 last_nxt;

  function automatic logic [BIN_WIDTH-1:0] pick(
    input logic [POS_WIDTH-1:0] w
  );
    logic [BIN_WIDTH-1:0] idx;
    idx = '0;
    // last match wins, so scan direction selects priority
    for (int i = 0; i < POS_WIDTH; i++) begin
      if (MSB_FIRST) begin
        if (w[i]) idx = BIN_WIDTH'(i);
      end else begin
        if (w[POS_WIDTH-1-i]) idx = BIN_WIDTH'(POS_WIDTH-1-i);
      end
    end
    return idx;
  endfunction

  function automatic logic [BIN_WIDTH:0] popcnt(
    input logic [POS_WIDTH-1:0] w
  );
    logic [BIN_WIDTH:0] c;
    c = '0;
    for (int i = 0; i < POS_WIDTH; i++) begin
      c = c + CW'(w[i]);
    end
    return c;
  endfunction

  function automatic logic one_hot(
    input logic [POS_WIDTH-1:0] w
  );
    return (w != '0) &&
      ((w & (w - POS_WIDTH'(1))) == '0);
  endfunction

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    hot_nxt   = hot_cnt;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pos_valid) begin
          if (pos != '0) begin
            work_nxt  = pos;
            hot_nxt   = popcnt(pos);
            state_nxt = EMIT;
          end else begin
            hot_nxt = '0;
            err_nxt = 1'b1;
          end
        end
      end
      EMIT: begin
        if (abort) begin
          work_nxt  = '0;
          state_nxt = IDLE;
        end else if (bin_ready) begin
          work_nxt[bin] = 1'b0;
          if (bin_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    bin_nxt  = '0;
    last_nxt = 1'b0;
    if (state_nxt == EMIT) begin
      bin_nxt  = pick(work_nxt);
      last_nxt = one_hot(work_nxt);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      work       <= '0;
      bin        <= '0;
      bin_last   <= 1'b0;
      hot_cnt    <= '0;
      err_no_hot <= 1'b0;
    end else begin
      state      <= state_nxt;
      work       <= work_nxt;
      bin        <= bin_nxt;
      bin_last   <= last_nxt;
      hot_cnt    <= hot_nxt;
      err_no_hot <= err_nxt;
    end
  end

  assign pos_ready = (state == IDLE);
  assign bin_valid = (state == EMIT);

endmodule

// File: tb/tb_pos2bin_stream.sv
// Bench for pos2bin_stream: LSB-first and MSB-first instances on shared
// stimulus, checked against a queue-based model of pending indices.
module tb_pos2bin_stream;

  logic       clk = 1'b0;
  logic       nrst;
  logic       pos_valid;
  logic [7:0] pos;
  logic       bin_ready;
  logic       abort;

  logic       pr0, bv0, bl0, er0;
  logic [2:0] b0;
  logic [3:0] hc0;
  logic       pr1, bv1, bl1, er1;
  logic [2:0] b1;
  logic [3:0] hc1;

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];
  int m_hot = 0;
  bit m_err = 0;

  pos2bin_stream #(.BIN_WIDTH(3), .POS_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .nrst(nrst),
    .pos_valid(pos_valid), .pos_ready(pr0), .pos(pos),
    .bin_valid(bv0), .bin_ready(bin_ready), .bin(b0),
    .bin_last(bl0), .hot_cnt(hc0), .err_no_hot(er0), .abort(abort)
  );

  pos2bin_stream #(.BIN_WIDTH(3), .POS_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .nrst(nrst),
    .pos_valid(pos_valid), .pos_ready(pr1), .pos(pos),
    .bin_valid(bv1), .bin_ready(bin_ready), .bin(b1),
    .bin_last(bl1), .hot_cnt(hc1), .err_no_hot(er1), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int e0, e1;
    e0 = (q0.size() != 0) ? q0[0] : 0;
    e1 = (q1.size() != 0) ? q1[0] : 0;
    chk("pos_ready0", pr0, q0.size() == 0);
    chk("bin_valid0", bv0, q0.size() != 0);
    chk("bin0", b0, e0);
    chk("bin_last0", bl0, q0.size() == 1);
    chk("hot_cnt0", hc0, m_hot);
    chk("err0", er0, m_err);
    chk("pos_ready1", pr1, q1.size() == 0);
    chk("bin_valid1", bv1, q1.size() != 0);
    chk("bin1", b1, e1);
    chk("bin_last1", bl1, q1.size() == 1);
    chk("hot_cnt1", hc1, m_hot);
    chk("err1", er1, m_err);
  endtask

  // One clock edge of the reference: pending indices live in a queue.
  task automatic model_edge();
    if (q0.size() == 0) begin
      m_err = 0;
      if (pos_valid) begin
        if (pos != 8'h00) begin
          for (int i = 0; i < 8; i++) begin
            if (pos[i]) begin
              q0.push_back(i);
              q1.push_front(i);
            end
          end
          m_hot = $countones(pos);
        end else begin
          m_err = 1;
          m_hot = 0;
        end
      end
    end else begin
      m_err = 0;
      if (abort) begin
        q0.delete();
        q1.delete();
      end else if (bin_ready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  typedef struct {
    logic [7:0] p;
    int lsb;
    int msb;
    int cnt;
  } vec_t;

  vec_t tbl[6];
  int   t2[5];
  int   r2[5];

  initial begin
    tbl[0] = '{8'h01, 0, 0, 1};
    tbl[1] = '{8'h80, 7, 7, 1};
    tbl[2] = '{8'h18, 3, 4, 2};
    tbl[3] = '{8'h81, 0, 7, 2};
    tbl[4] = '{8'h5A, 1, 6, 4};
    tbl[5] = '{8'hFF, 0, 7, 8};

    nrst = 1'b0; pos_valid = 0; pos = 0;
    bin_ready = 0; abort = 0;
    #12;
    check_all();
    #5 nrst = 1'b1;
    cycle();

    // table: first beat and popcount, then drain
    for (int k = 0; k < 6; k++) begin
      pos_valid = 1; pos = tbl[k].p; bin_ready = 1;
      cycle();
      pos_valid = 0;
      chk("tbl_lsb", b0, tbl[k].lsb);
      chk("tbl_msb", b1, tbl[k].msb);
      chk("tbl_cnt", hc0, tbl[k].cnt);
      chk("tbl_last", bl0, tbl[k].cnt == 1);
      repeat (tbl[k].cnt) cycle();
      chk("tbl_idle", pr0, 1);
    end

    // 1: A4 at full rate
    pos_valid = 1; pos = 8'hA4; bin_ready = 1;
    cycle();
    pos_valid = 0;
    chk("t1_b2", b0, 2); chk("t1_hot", hc0, 3);
    cycle();
    chk("t1_b5", b0, 5); chk("t1_nl", bl0, 0);
    cycle();
    chk("t1_b7", b0, 7); chk("t1_last", bl0, 1);
    cycle();
    chk("t1_ready", pr0, 1); chk("t1_hold", hc0, 3);

    // 2: stalls hold 5 for three cycles
    t2 = '{5, 5, 5, 7, 0};
    r2 = '{1, 0, 0, 1, 1};
    pos_valid = 1; pos = 8'hA4;
    cycle();
    pos_valid = 0;
    chk("t2_b2", b0, 2);
    for (int i = 0; i < 5; i++) begin
      bin_ready = r2[i][0];
      cycle();
      chk("t2_seq", b0, t2[i]);
    end
    chk("t2_idle", bv0, 0);

    // 3: all-zero vector
    pos_valid = 1; pos = 8'h00;
    cycle();
    pos_valid = 0;
    chk("t3_err", er0, 1); chk("t3_hot", hc0, 0);
    chk("t3_bv", bv0, 0); chk("t3_pr", pr0, 1);
    cycle();
    chk("t3_pulse", er0, 0);

    // 4: MSB-first full vector
    pos_valid = 1; pos = 8'hFF; bin_ready = 1;
    cycle();
    pos_valid = 0;
    chk("t4_hot", hc1, 8);
    for (int i = 7; i >= 0; i--) begin
      chk("t4_seq", b1, i);
      chk("t4_last", bl1, i == 0);
      cycle();
    end
    chk("t4_idle", bv1, 0);

    // 5: abort with second handshake
    pos_valid = 1; pos = 8'hFF;
    cycle();
    pos_valid = 0;
    cycle();
    chk("t5_b1", b0, 1);
    abort = 1;
    cycle();
    abort = 0;
    chk("t5_bv", bv0, 0); chk("t5_pr", pr0, 1);
    pos_valid = 1; pos = 8'h10;
    cycle();
    pos_valid = 0;
    chk("t5_b4", b0, 4); chk("t5_last", bl0, 1);
    cycle();
    chk("t5_done", bv0, 0);

    // 6: async reset during third beat
    pos_valid = 1; pos = 8'hFF;
    cycle();
    pos_valid = 0;
    cycle();
    cycle();
    chk("t6_b2", b0, 2);
    #2 nrst = 1'b0;
    #1;
    q0.delete(); q1.delete();
    m_hot = 0; m_err = 0;
    check_all();
    #13 nrst = 1'b1;
    repeat (3) cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      pos_valid = ($urandom % 2) == 0;
      case ($urandom % 6)
        0: pos = 8'h00;
        1: pos = 8'hFF;
        default: pos = 8'($urandom);
      endcase
      bin_ready = ($urandom % 4) != 0;
      abort = ($urandom % 10) == 0;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
